io_max_pipe: RTL



---
 rtl/io_max_pipe.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/io_max_pipe.sv
// Pipelined IO-max mux/demux block: scrambled bit select, one-hot demux, fold onto OUT_W outputs.
// Optional parity output when IO_MAX_PIPE_PARITY_EN is defined.
module io_max_pipe #(
    parameter int MUX_SEL_W = 9,
    parameter int DMX_SEL_W = 9,
    parameter int OUT_W     = 500,
    parameter int COM_W     = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [(2**MUX_SEL_W)-1:0]    mux_in,
    input  logic [MUX_SEL_W-1:0]         mux_sel,
    input  logic [COM_W-1:0]             com_sel,
    input  logic [DMX_SEL_W-1:0]         demux_sel,
    input  logic [1:0]                   mode,
    input  logic                         start,
    output logic [OUT_W-1:0]             demux_out,
    output logic                         valid_out,
    output logic                         sweep_busy,
`ifdef IO_MAX_PIPE_PARITY_EN
    output logic                         parity_out,
`endif
    output logic                         sweep_done
);
    localparam int IN_W  = 2**MUX_SEL_W;
    localparam int DMX_W = 2**DMX_SEL_W;
    localparam logic [MUX_SEL_W-1:0] CNT_MAX = '1;

    localparam logic [1:0] MODE_DIRECT = 2'b01;
    localparam logic [1:0] MODE_SWEEP  = 2'b10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DIRECT = 2'd1,
        SWEEP  = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t               state;
    logic [MUX_SEL_W-1:0] counter;

    logic [IN_W-1:0]      s1_data;
    logic [MUX_SEL_W-1:0] s1_sel;
    logic [DMX_SEL_W-1:0] s1_dsel;
    logic                 s1_valid;
    logic                 s1_last;

    logic                 s2_bit;
    logic [DMX_SEL_W-1:0] s2_dsel;
    logic                 s2_valid;
    logic                 s2_last;

    logic [DMX_W-1:0]     w;
    logic [OUT_W-1:0]     fold;

    logic launch;
    logic cnt_last;
    logic sweep_stay;

    // A launch is only honoured from IDLE with no earlier sweep still draining.
    assign launch     = (state == IDLE) && (mode == MODE_SWEEP) && start && !sweep_busy;
    assign cnt_last   = (state == SWEEP) && (counter == CNT_MAX);
    assign sweep_stay = (state == SWEEP) && (mode == MODE_SWEEP);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            counter    <= '0;
            sweep_busy <= 1'b0;
        end else begin
            // Busy covers the sweep states and stays up until the final result has left S3.
            sweep_busy <= launch || sweep_stay || cnt_last || s1_last || s2_last;
            case (state)
                IDLE: begin
                    if (mode == MODE_DIRECT) begin
                        state <= DIRECT;
                    end else if (launch) begin
                        state   <= SWEEP;
                        counter <= '0;
                    end
                end
                DIRECT: begin
                    if (mode != MODE_DIRECT) state <= IDLE;
                end
                SWEEP: begin
                    if (mode != MODE_SWEEP) begin
                        state <= IDLE;
                    end else if (counter == CNT_MAX) begin
                        state <= DONE;
                    end else begin
                        counter <= counter + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_data  <= '0;
            s1_sel   <= '0;
            s1_dsel  <= '0;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s2_bit   <= 1'b0;
            s2_dsel  <= '0;
            s2_valid <= 1'b0;
            s2_last  <= 1'b0;
        end else begin
            s1_data  <= mux_in;
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            case (state)
                DIRECT: begin
                    s1_sel   <= mux_sel ^ MUX_SEL_W'(com_sel);
                    s1_dsel  <= demux_sel;
                    s1_valid <= 1'b1;
                end
                SWEEP: begin
                    s1_sel   <= counter;
                    s1_dsel  <= DMX_SEL_W'(counter);
                    s1_valid <= 1'b1;
                    s1_last  <= cnt_last;
                end
                default: ;
            endcase
            s2_bit   <= s1_data[s1_sel];
            s2_dsel  <= s1_dsel;
            s2_valid <= s1_valid;
            s2_last  <= s1_last;
        end
    end

    always_comb begin
        w = DMX_W'(s2_bit) << s2_dsel;
    end

    // Internal bit OUT_W+i folds onto output bit i; bits with no upper partner pass through.
    for (genvar i = 0; i < OUT_W; i++) begin : g_fold
        if (i + OUT_W < DMX_W) begin : g_pair
            assign fold[i] = w[i] ^ w[i+OUT_W];
        end else begin : g_single
            assign fold[i] = w[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !s2_valid) begin
            demux_out  <= '0;
            valid_out  <= 1'b0;
            sweep_done <= 1'b0;
`ifdef IO_MAX_PIPE_PARITY_EN
            parity_out <= 1'b0;
`endif
        end else begin
            demux_out  <= fold;
            valid_out  <= 1'b1;
            sweep_done <= s2_last;
`ifdef IO_MAX_PIPE_PARITY_EN
            parity_out <= ^fold;
`endif
        end
    end
endmodule
